sync_preamble_tx: RTL and testbench

Transmit-side frame builder for the I/Q sync link. On a start request it emits a fixed PN-sequence preamble, repeated a configurable number of times, as signed 32-bit I/Q symbols. It then BPSK-maps a fixed-length payload bitstream taken from an upstream valid/ready source. The output drives the modulator path whose far end performs correlation and energy-threshold sync detection on the same preamble.

---
 rtl/sync_preamble_tx.sv | 157 +++++++++++++++
 tb/tb_sync_preamble_tx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_preamble_tx.sv
// rtl/sync_preamble_tx.sv - PN preamble + BPSK payload frame builder for the I/Q sync link.
// Optional SYNC_TX_INVERT_LAST_EN: final preamble repetition sent with inverted polarity.
module sync_preamble_tx #(
  parameter int unsigned        PRE_REPS    = 4,
  parameter int unsigned        PAYLOAD_LEN = 64,
  parameter logic signed [31:0] AMP         = 32'sh00004000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  input  logic               tx_data,
  input  logic               tx_data_valid,
  output logic               tx_data_ready,
  output logic signed [31:0] out_i,
  output logic signed [31:0] out_q,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               frame_done
);

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_PAYLOAD, S_FLUSH} state_t;

  localparam logic [4:0]  SEED     = 5'b11111;
  localparam logic [4:0]  LAST_CHIP = 5'd30;
  localparam logic [3:0]  LAST_REP = 4'(PRE_REPS - 1);
  localparam logic [15:0] LAST_BIT = 16'(PAYLOAD_LEN - 1);

  state_t             state_q, state_d;
  logic [4:0]         lfsr_q, lfsr_d;
  logic [4:0]         chip_q, chip_d;
  logic [3:0]         rep_q, rep_d;
  logic [15:0]        bit_q, bit_d;
  logic signed [31:0] out_i_q, out_i_d;
  logic signed [31:0] out_q_q, out_q_d;
  logic               out_valid_q, out_valid_d;
  logic               frame_done_q, frame_done_d;
  logic               slot_free;
  logic               inv_last;
  logic               pos;

`ifdef SYNC_TX_INVERT_LAST_EN
  assign inv_last = 1'b1;
`else
  assign inv_last = 1'b0;
`endif

  function automatic logic [4:0] lfsr_step(input logic [4:0] l);
    return {l[0] ^ l[2], l[4:1]};
  endfunction

  // A new symbol may be loaded whenever the output register is empty or being drained.
  assign slot_free = !out_valid_q || out_ready;

  always_comb begin
    state_d       = state_q;
    lfsr_d        = lfsr_q;
    chip_d        = chip_q;
    rep_d         = rep_q;
    bit_d         = bit_q;
    out_i_d       = out_i_q;
    out_q_d       = out_q_q;
    out_valid_d   = out_valid_q;
    frame_done_d  = 1'b0;
    tx_data_ready = 1'b0;
    pos           = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pos         = SEED[0] ^ (inv_last && (LAST_REP == 4'd0));
          out_i_d     = pos ? AMP : -AMP;
          out_q_d     = pos ? AMP : -AMP;
          out_valid_d = 1'b1;
          lfsr_d      = lfsr_step(SEED);
          chip_d      = 5'd1;
          rep_d       = 4'd0;
          bit_d       = 16'd0;
          state_d     = S_PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        if (slot_free) begin
          pos         = lfsr_q[0] ^ (inv_last && (rep_q == LAST_REP));
          out_i_d     = pos ? AMP : -AMP;
          out_q_d     = pos ? AMP : -AMP;
          out_valid_d = 1'b1;
          if (chip_q == LAST_CHIP) begin
            lfsr_d = SEED;
            chip_d = 5'd0;
            if (rep_q == LAST_REP) begin
              bit_d   = 16'd0;
              state_d = S_PAYLOAD;
            end else begin
              rep_d = rep_q + 4'd1;
            end
          end else begin
            lfsr_d = lfsr_step(lfsr_q);
            chip_d = chip_q + 5'd1;
          end
        end
      end
      S_PAYLOAD: begin
        tx_data_ready = slot_free;
        if (slot_free) begin
          if (tx_data_valid) begin
            out_i_d     = tx_data ? AMP : -AMP;
            out_q_d     = '0;
            out_valid_d = 1'b1;
            bit_d       = bit_q + 16'd1;
            if (bit_q == LAST_BIT) state_d = S_FLUSH;
          end else begin
            out_valid_d = 1'b0;
          end
        end
      end
      S_FLUSH: begin
        if (out_valid_q && out_ready) begin
          out_valid_d  = 1'b0;
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lfsr_q       <= SEED;
      chip_q       <= '0;
      rep_q        <= '0;
      bit_q        <= '0;
      out_i_q      <= '0;
      out_q_q      <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      chip_q       <= chip_d;
      rep_q        <= rep_d;
      bit_q        <= bit_d;
      out_i_q      <= out_i_d;
      out_q_q      <= out_q_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign out_i      = out_i_q;
  assign out_q      = out_q_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sync_preamble_tx.sv
// tb/tb_sync_preamble_tx.sv - directed self-checking bench for sync_preamble_tx.
module tb_sync_preamble_tx;
  localparam int                 PRE  = 4;
  localparam int                 PLEN = 64;
  localparam logic signed [31:0] AMP  = 32'sh00004000;
  localparam int                 NPRE = 31 * PRE;

  logic clk = 1'b0;
  logic reset, start, busy, tx_data, tx_data_valid, tx_data_ready;
  logic out_valid, out_ready, frame_done;
  logic signed [31:0] out_i, out_q;

  sync_preamble_tx #(.PRE_REPS(PRE), .PAYLOAD_LEN(PLEN), .AMP(AMP)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
    .out_i(out_i), .out_q(out_q), .out_valid(out_valid), .out_ready(out_ready),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic signed [31:0] sym_i[$];
  logic signed [31:0] sym_q[$];
  logic signed [31:0] held_i;
  int hs_first, hs_last, acc_cnt, bubbles, done_cnt, done_cyc, hold_err;
  int stall_hs, stall_left, gap_bit, gap_left, busy_start_cyc;
  bit restart_en;
  logic first_busy, first_valid;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] exp_pre(input int k);
    int rep;
    int c;
    logic [4:0] l;
    logic p;
    rep = k / 31;
    c   = k % 31;
    l   = 5'b11111;
    for (int j = 0; j < c; j++) l = {l[0] ^ l[2], l[4:1]};
    p = l[0];
`ifdef SYNC_TX_INVERT_LAST_EN
    if (rep == PRE - 1) p = !p;
`endif
    return p ? AMP : -AMP;
  endfunction

  task automatic run_frame(input int max_cyc);
    logic stalled;
    sym_i.delete(); sym_q.delete();
    hs_first = -1; hs_last = -1; acc_cnt = 0; bubbles = 0;
    done_cnt = 0; done_cyc = -1; hold_err = 0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge clk);
      stalled       = (sym_i.size() == stall_hs) && (stall_left > 0);
      out_ready     = !stalled;
      tx_data_valid = !((acc_cnt == gap_bit) && (gap_left > 0));
      if (!tx_data_valid) gap_left--;
      tx_data       = (acc_cnt % 2 == 0);
      start         = (restart_en && frame_done) || (cyc == busy_start_cyc);
      #1;
      if (cyc == 0) begin first_busy = busy; first_valid = out_valid; end
      if (stalled) begin
        if (stall_left == 3) held_i = out_i;
        else if (out_i !== held_i || out_valid !== 1'b1) hold_err++;
        stall_left--;
      end
      if (out_valid && out_ready) begin
        if (hs_first < 0) hs_first = cyc;
        hs_last = cyc;
        sym_i.push_back(out_i);
        sym_q.push_back(out_q);
      end
      if (tx_data_valid && tx_data_ready) acc_cnt++;
      if (busy && !out_valid) bubbles++;
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic check_seq(input string tag);
    int errs;
    logic signed [31:0] ei, eq;
    errs = 0;
    for (int k = 0; k < sym_i.size(); k++) begin
      if (k < NPRE) begin ei = exp_pre(k); eq = ei; end
      else begin ei = ((k - NPRE) % 2 == 0) ? AMP : -AMP; eq = 0; end
      if (sym_i[k] !== ei || sym_q[k] !== eq) errs++;
    end
    check(tag, errs, 0);
  endtask

  initial begin
    int pos_cnt;
    int blk_err;
    reset = 1'b1; start = 1'b0; tx_data = 1'b0; tx_data_valid = 1'b0; out_ready = 1'b1;
    stall_hs = 10; stall_left = 0; gap_bit = 20; gap_left = 0;
    busy_start_cyc = -1; restart_en = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_i", out_i, 0);
    check("rst_out_q", out_q, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_tx_ready", tx_data_ready, 0);
    @(negedge clk); reset = 1'b0;

    // Frame 1: clean run, extra start while busy must be ignored.
    @(negedge clk); start = 1'b1;
    busy_start_cyc = 50;
    run_frame(400);
    busy_start_cyc = -1;
    check("f1_done_seen", done_cnt, 1);
    check("f1_start_busy", first_busy, 1);
    check("f1_start_valid", first_valid, 1);
    check("f1_hs_first", hs_first, 0);
    check("f1_count", sym_i.size(), NPRE + PLEN);
    check("f1_no_bubble", hs_last - hs_first, NPRE + PLEN - 1);
    check("f1_bubbles", bubbles, 0);
    check("f1_accepted", acc_cnt, PLEN);
    check("f1_done_timing", done_cyc, hs_last + 1);
    check("chip0_i", sym_i[0], AMP);
    check("chip4_i", sym_i[4], AMP);
    check("chip4_q", sym_q[4], AMP);
    check("chip5_i", sym_i[5], -AMP);
    check("chip5_q", sym_q[5], -AMP);
    pos_cnt = 0;
    for (int k = 0; k < 31; k++) if (sym_i[k] == AMP) pos_cnt++;
    check("blk0_pos", pos_cnt, 16);
    blk_err = 0;
    for (int b = 1; b < PRE - 1; b++)
      for (int k = 0; k < 31; k++) if (sym_i[b*31+k] !== sym_i[k]) blk_err++;
    check("blk_same", blk_err, 0);
`ifdef SYNC_TX_INVERT_LAST_EN
    check("last_rep_c0", sym_i[93], -AMP);
    check("last_rep_c4", sym_q[97], -AMP);
`else
    check("last_rep_c0", sym_i[93], AMP);
    check("last_rep_c4", sym_q[97], AMP);
`endif
    check("pay0_i", sym_i[NPRE], AMP);
    check("pay1_i", sym_i[NPRE+1], -AMP);
    check("pay1_q", sym_q[NPRE+1], 0);
    check_seq("f1_seq");
    @(negedge clk); start = 1'b0; #1;
    check("f1_done_clear", frame_done, 0);
    check("f1_idle_busy", busy, 0);
    repeat (10) @(negedge clk);
    #1;
    check("no_second_busy", busy, 0);
    check("no_second_valid", out_valid, 0);

    // Frame 2: stall at chip 10, gap mid-payload, restart in frame_done cycle.
    @(negedge clk); start = 1'b1;
    stall_left = 3; gap_left = 2; restart_en = 1'b1;
    run_frame(400);
    restart_en = 1'b0;
    check("f2_done_seen", done_cnt, 1);
    check("f2_hold", hold_err, 0);
    check("f2_count", sym_i.size(), NPRE + PLEN);
    check("f2_bubbles", bubbles, 2);
    check("f2_accepted", acc_cnt, PLEN);
    check("f2_chip11", sym_i[11], exp_pre(11));
    check_seq("f2_seq");
    @(negedge clk); start = 1'b0; #1;
    check("restart_busy", busy, 1);
    check("restart_valid", out_valid, 1);
    check("restart_chip0", out_i, AMP);
    check("restart_done_clear", frame_done, 0);
    run_frame(400);
    check("f3_done_seen", done_cnt, 1);
    check("f3_count", sym_i.size(), NPRE + PLEN - 1);

    // Asynchronous reset mid-preamble under backpressure.
    @(negedge clk); start = 1'b1; out_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("pre_rst_busy", busy, 1);
    #1 reset = 1'b1;
    #1;
    check("arst_out_i", out_i, 0);
    check("arst_out_q", out_q, 0);
    check("arst_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_done", frame_done, 0);
    check("arst_ready", tx_data_ready, 0);
    @(negedge clk); reset = 1'b0; out_ready = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("post_rst_valid", out_valid, 0);
    check("post_rst_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
